// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: data_in_0 - data_in_1 - borrow_in, one bit per clock, LSB first.
// A single registered borrow stage walks the operands; the result shifts into the
// vacated MSB end of the minuend register, so no separate accumulator is needed.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              brw_q;
  logic [WIDTH-1:0]  data_out_q;
  logic              borrow_out_q, overflow_q, zero_q;

  logic              load, step, last;
  logic              a_bit, b_bit, diff_bit, brw_next;
  logic [WIDTH-1:0]  res_next;

  // One full-subtractor cell on the current LSBs; result enters at the top of a_q.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    diff_bit = a_bit ^ b_bit ^ brw_q;
    brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
    res_next = {diff_bit, a_q[WIDTH-1:1]};
    last     = (cnt_q == CntW'(WIDTH - 1));
  end

  // Control: next state and datapath enables.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        step = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          load    = 1'b1;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Operand/borrow shifting and result capture on the final bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      brw_q        <= 1'b0;
      data_out_q   <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else if (load) begin
      cnt_q <= '0;
      a_q   <= data_in_0;
      b_q   <= data_in_1;
      brw_q <= borrow_in;
    end else if (step) begin
      cnt_q <= cnt_q + CntW'(1);
      a_q   <= res_next;
      b_q   <= {1'b0, b_q[WIDTH-1:1]};
      brw_q <= brw_next;
      if (last) begin
        // On the last bit a_bit/b_bit are the operand sign bits and diff_bit is the result sign.
        data_out_q   <= res_next;
        borrow_out_q <= brw_next;
        overflow_q   <= (a_bit != b_bit) && (diff_bit != a_bit);
        zero_q       <= (res_next == '0);
      end
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign data_out   = data_out_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in_0;
  logic [WIDTH-1:0] data_in_1;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  int n_cmp = 0;
  int n_err = 0;

  // Expected results of the operation in flight, and what the outputs should hold.
  logic [WIDTH-1:0] exp_d;
  logic             exp_b, exp_v, exp_z;
  logic [WIDTH-1:0] held_out;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: wide unsigned subtraction for result/borrow, signed integer range for overflow.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH:0] t;
    longint sd, smax, smin;
    t     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    exp_d = t[WIDTH-1:0];
    exp_b = t[WIDTH];
    sd    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    smax  = (longint'(1) << (WIDTH - 1)) - 1;
    smin  = -(longint'(1) << (WIDTH - 1));
    exp_v = (sd > smax) || (sd < smin);
    exp_z = (exp_d == '0);
  endtask

  // Present a request at the current (negedge) time; accepted at the next posedge.
  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic bin);
    start     = 1'b1;
    data_in_0 = a;
    data_in_1 = b;
    borrow_in = bin;
    model(a, b, bin);
  endtask

  // Wait through the operation; returns at the negedge where done is high (or bound expired).
  task automatic wait_done(input string tag, input bit hold);
    int cyc  = 0;
    int bcnt = 0;
    bit seen = 0;
    @(posedge clock);
    #1 start = hold;
    while (!seen && cyc < int'(WIDTH) + 8) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) check({tag, "_held"}, 64'(data_out), 64'(held_out));
      if (done) begin
        seen = 1;
      end else begin
        if (busy) bcnt++;
        if (hold) begin
          data_in_0 = $urandom;
          data_in_1 = $urandom;
          borrow_in = 1'($urandom);
        end
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(WIDTH + 1));
    check({tag, "_busycnt"}, 64'(bcnt), 64'(WIDTH));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "_data"}, 64'(data_out), 64'(exp_d));
    check({tag, "_borrow"}, 64'(borrow_out), 64'(exp_b));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_v));
    check({tag, "_zero"}, 64'(zero), 64'(exp_z));
    held_out = exp_d;
  endtask

  // Idle cycles: done must not repeat and results must hold.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check({tag, "_idle_done"}, 64'(done), 64'(0));
      check({tag, "_idle_busy"}, 64'(busy), 64'(0));
      check({tag, "_idle_hold"}, 64'(data_out), 64'(held_out));
    end
  endtask

  task automatic op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic bin);
    drive_start(a, b, bin);
    wait_done(tag, 1'b0);
    idle(tag, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_data"}, 64'(data_out), 64'(0));
    check({tag, "_borrow"}, 64'(borrow_out), 64'(0));
    check({tag, "_ovf"}, 64'(overflow), 64'(0));
    check({tag, "_zero"}, 64'(zero), 64'(0));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    data_in_0 = '0;
    data_in_1 = '0;
    borrow_in = 1'b0;
    held_out  = '0;
    #1;
    check_cleared("reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle("post_reset", 2);

    op("basic",     32'h0000_0005, 32'h0000_0003, 1'b0);
    op("underflow", 32'h0000_0003, 32'h0000_0005, 1'b0);
    op("ovf_neg",   32'h8000_0000, 32'h0000_0001, 1'b0);
    op("ovf_pos",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    op("equal",     32'h1234_5678, 32'h1234_5678, 1'b0);
    op("equal_bin", 32'h1234_5678, 32'h1234_5678, 1'b1);

    // start held high with operands churning during SHIFT
    drive_start(32'h0000_1000, 32'h0000_0001, 1'b0);
    wait_done("start_held", 1'b1);

    // back-to-back: new request in the DONE cycle
    drive_start(32'd10, 32'd4, 1'b0);
    wait_done("b2b", 1'b0);
    idle("b2b", 2);

    // reset 10 cycles into SHIFT
    drive_start(32'hDEAD_BEEF, 32'h0000_0123, 1'b1);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_cleared("mid_reset");
    held_out = '0;
    for (int i = 0; i < int'(WIDTH) + 4; i++) begin
      @(negedge clock);
      check("mid_reset_no_done", 64'(done), 64'(0));
      if (i == 2) reset = 1'b0;
    end
    op("after_reset", 32'd9, 32'd9, 1'b0);

    // random operations, some with start held through SHIFT
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rbin;
      bit               rhold;
      ra    = $urandom;
      rb    = $urandom;
      rbin  = 1'($urandom);
      rhold = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      drive_start(ra, rb, rbin);
      wait_done($sformatf("rand%0d", i), rhold);
      idle($sformatf("rand%0d", i), 1 + (i % 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle bit-serial subtractor: computes data_in_0 - data_in_1 - borrow_in one bit per clock, LSB first.
- Uses a single registered borrow stage, the subtract-direction counterpart of the 1-bit full-adder cell.
- Sits beside the ALU as a low-area subtract/compare unit; the controller drives it with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 2).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- data_in_0  input  WIDTH  minuend, latched on accepted start
- data_in_1  input  WIDTH  subtrahend, latched on accepted start
- borrow_in  input  1  initial borrow, latched on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- data_out  output  WIDTH  difference
- borrow_out  output  1  final borrow (1 = unsigned underflow)
- overflow  output  1  signed overflow
- zero  output  1  data_out == 0

Behaviour:
- Reset (async assert, any state): state=IDLE, bit counter=0, internal borrow=0, operand shift registers=0.
  - All outputs drop to 0 on reset: busy, done, data_out, borrow_out, overflow, zero.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> latch operands and borrow_in, counter=0, go to SHIFT. Otherwise stay.
  - SHIFT: busy=1. Each edge processes bit i = counter.
    - d_i = a_i ^ b_i ^ brw
    - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
    - d_i shifts into the result MSB end (result register shifts right), so after WIDTH edges bit 0 sits at the LSB.
    - Counter increments. On the edge processing bit WIDTH-1, go to DONE.
  - DONE: done=1 for exactly one cycle. Next edge: start=1 -> accept new operation and go to SHIFT (back-to-back); else go to IDLE.
- Latency: start sampled at edge E0; done=1 during the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance. busy=1 for exactly WIDTH cycles.
- start while in SHIFT: ignored, no effect on the operation in flight. Operand inputs are don't-care except on the accepting edge.
- Result outputs update only at the SHIFT->DONE transition. They hold their value through IDLE and during the next SHIFT, until the next DONE.
- borrow_out = final brw.
- overflow = (A[WIDTH-1] != B[WIDTH-1]) && (data_out[WIDTH-1] != A[WIDTH-1]), where A and B are the latched operands. borrow_in is included in the difference.
- zero = (data_out == 0), registered together with data_out.
- Reset mid-SHIFT: aborts the operation, no done pulse, outputs cleared. First start after reset deassertion behaves normally.
- Arithmetic is modulo 2^WIDTH, with no saturation.

Test Plan:
- Basic subtract (WIDTH=32): A=0x00000005, B=0x00000003, borrow_in=0, start 1 cycle.
  - Expect: busy 32 cycles, done pulse 32 cycles after acceptance.
  - Expect: data_out=0x00000002, borrow_out=0, overflow=0, zero=0.
- Unsigned underflow: A=0x00000003, B=0x00000005, borrow_in=0.
  - Expect: data_out=0xFFFFFFFE, borrow_out=1, overflow=0, zero=0.
- Signed overflow: A=0x80000000, B=0x00000001.
  - Expect: data_out=0x7FFFFFFF, overflow=1, borrow_out=0.
  - Then A=0x7FFFFFFF, B=0xFFFFFFFF -> data_out=0x80000000, overflow=1, borrow_out=1.
- Equal operands and borrow_in: A=B=0x12345678, borrow_in=0 -> data_out=0, zero=1, borrow_out=0.
  - Same operands with borrow_in=1 -> data_out=0xFFFFFFFF, zero=0, borrow_out=1.
- Handshake edge cases:
  - start held high and operands changed during SHIFT -> ignored, result matches first operands.
  - start=1 in the DONE cycle with A=10, B=4 -> immediate re-entry to SHIFT, next done gives 0x00000006.
  - reset asserted 10 cycles into SHIFT -> all outputs 0 immediately, no done pulse. A following start (A=9, B=9) completes normally with zero=1.
